// File: rtl/pong_pkg.sv
// Shared encodings for the pong match controller: FSM states, winner codes
// and active-low seven-segment patterns.
package pong_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_POINT = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    // Segment order {g,f,e,d,c,b,a}; a low bit lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

endpackage

// File: rtl/match_sequencer_if.sv
// Key/random inputs and game-control/score outputs of the match sequencer.
// The slave side is the sequencer; the master side is its environment.
interface match_sequencer_if;

    logic       start;
    logic       miss_left;
    logic       miss_right;
    logic       random;
    logic       game_run;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic [1:0] winner;
    logic [2:0] state;
    logic [6:0] hex_left;
    logic [6:0] hex_right;

    modport master (
        output start, miss_left, miss_right, random,
        input  game_run, ball_reset, serve_dir, score_left, score_right,
               winner, state, hex_left, hex_right
    );

    modport slave (
        input  start, miss_left, miss_right, random,
        output game_run, ball_reset, serve_dir, score_left, score_right,
               winner, state, hex_left, hex_right
    );

endinterface

// File: rtl/seg7_decoder.sv
// Binary-to-seven-segment decoder, active-low outputs; values above 9 blank.
module seg7_decoder
    import pong_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (value_i <= 4'd9) begin
            seg_o = SEG_DIGIT[value_i];
        end
    end

endmodule

// File: rtl/match_sequencer.sv
// Pong round/match controller: serve countdown, live play, point pause and
// game over; keeps both scores and drives their seven-segment digits.
module match_sequencer
    import pong_pkg::*;
#(
    parameter int TICK_DIV    = 500000,
    parameter int SERVE_TICKS = 100,
    parameter int POINT_TICKS = 150,
    parameter int WIN_SCORE   = 7
) (
    input  logic             CLOCK2_50,
    input  logic             rst,
    match_sequencer_if.slave seq_if
);

    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]      SERVE_LOAD = 8'(SERVE_TICKS);
    localparam logic [7:0]      POINT_LOAD = 8'(POINT_TICKS);
    localparam logic [3:0]      WIN_VALUE  = 4'(WIN_SCORE);

    logic [2:0]    state_q, state_d;
    logic [3:0]    score_left_q, score_left_d;
    logic [3:0]    score_right_q, score_right_d;
    logic [1:0]    winner_q, winner_d;
    logic          serve_dir_q, serve_dir_d;
    logic          game_run_q, game_run_d;
    logic          ball_reset_q, ball_reset_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    timer_q, timer_d;
    logic          start_q;
    logic          start_edge;
    logic          tick;
    logic          expired;
    logic          load_timer;

    assign start_edge = seq_if.start & ~start_q;
    assign tick       = (presc_q == PRESC_LAST);
    // The phase ends on the tick that brings the timer to zero, so an N-tick
    // phase lasts exactly N*TICK_DIV cycles from the load.
    assign expired    = tick & (timer_q <= 8'd1);
    assign presc_d    = (load_timer || tick) ? '0 : presc_q + 1'b1;

    always_comb begin
        // NOTE: every next-state signal is given a default before the case so
        // that no path leaves it unassigned and no latch is inferred.
        state_d       = state_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        winner_d      = winner_q;
        serve_dir_d   = serve_dir_q;
        game_run_d    = 1'b0;
        ball_reset_d  = 1'b0;
        load_timer    = 1'b0;
        timer_d       = (tick && timer_q != 8'd0) ? timer_q - 8'd1 : timer_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    score_left_d  = '0;
                    score_right_d = '0;
                    winner_d      = WIN_NONE;
                    serve_dir_d   = seq_if.random;
                    ball_reset_d  = 1'b1;
                    load_timer    = 1'b1;
                    timer_d       = SERVE_LOAD;
                    state_d       = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (expired) begin
                    game_run_d = 1'b1;
                    state_d    = ST_PLAY;
                end
            end
            ST_PLAY: begin
                game_run_d = 1'b1;
                if (seq_if.miss_left && seq_if.miss_right) begin
                    serve_dir_d = seq_if.random;
                end else if (seq_if.miss_left) begin
                    score_right_d = score_right_q + 4'd1;
                    serve_dir_d   = 1'b0;
                end else if (seq_if.miss_right) begin
                    score_left_d = score_left_q + 4'd1;
                    serve_dir_d  = 1'b1;
                end
                if (seq_if.miss_left || seq_if.miss_right) begin
                    game_run_d = 1'b0;
                    // NOTE: blocking '=' in combinational logic means the
                    // score_*_d values read here are the ones just updated.
                    if (score_left_d == WIN_VALUE) begin
                        winner_d = WIN_LEFT;
                        state_d  = ST_OVER;
                    end else if (score_right_d == WIN_VALUE) begin
                        winner_d = WIN_RIGHT;
                        state_d  = ST_OVER;
                    end else begin
                        load_timer = 1'b1;
                        timer_d    = POINT_LOAD;
                        state_d    = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                if (expired) begin
                    ball_reset_d = 1'b1;
                    load_timer   = 1'b1;
                    timer_d      = SERVE_LOAD;
                    state_d      = ST_SERVE;
                end
            end
            default: begin
                score_left_d  = '0;
                score_right_d = '0;
                winner_d      = WIN_NONE;
                serve_dir_d   = 1'b0;
                load_timer    = 1'b1;
                timer_d       = '0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // Sampled through reset as well, so a key held across reset release is
    // not mistaken for a fresh press.
    always_ff @(posedge CLOCK2_50) begin
        start_q <= seq_if.start;
    end

    always_ff @(posedge CLOCK2_50) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            score_left_q  <= '0;
            score_right_q <= '0;
            winner_q      <= WIN_NONE;
            serve_dir_q   <= 1'b0;
            game_run_q    <= 1'b0;
            ball_reset_q  <= 1'b0;
            presc_q       <= '0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            winner_q      <= winner_d;
            serve_dir_q   <= serve_dir_d;
            game_run_q    <= game_run_d;
            ball_reset_q  <= ball_reset_d;
            presc_q       <= presc_d;
            timer_q       <= timer_d;
        end
    end

    assign seq_if.state       = state_q;
    assign seq_if.score_left  = score_left_q;
    assign seq_if.score_right = score_right_q;
    assign seq_if.winner      = winner_q;
    assign seq_if.serve_dir   = serve_dir_q;
    assign seq_if.game_run    = game_run_q;
    assign seq_if.ball_reset  = ball_reset_q;

    seg7_decoder u_hex_left (
        .value_i (score_left_q),
        .seg_o   (seq_if.hex_left)
    );

    seg7_decoder u_hex_right (
        .value_i (score_right_q),
        .seg_o   (seq_if.hex_right)
    );

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer: directed vector table, corner
// sequences around start/reset, and randomized play against a phase model.
module tb_match_sequencer;

    localparam int TICK_DIV    = 4;
    localparam int SERVE_TICKS = 3;
    localparam int POINT_TICKS = 2;
    localparam int WIN_SCORE   = 3;
    localparam int SERVE_CYC   = SERVE_TICKS * TICK_DIV;
    localparam int POINT_CYC   = POINT_TICKS * TICK_DIV;

    logic CLOCK2_50 = 1'b0;
    logic rst;

    match_sequencer_if seq_if ();

    match_sequencer #(
        .TICK_DIV    (TICK_DIV),
        .SERVE_TICKS (SERVE_TICKS),
        .POINT_TICKS (POINT_TICKS),
        .WIN_SCORE   (WIN_SCORE)
    ) dut (
        .CLOCK2_50 (CLOCK2_50),
        .rst       (rst),
        .seq_if    (seq_if)
    );

    logic [3:0] seg_val;
    logic [6:0] seg_out;

    seg7_decoder u_seg (
        .value_i (seg_val),
        .seg_o   (seg_out)
    );

    always #10 CLOCK2_50 = ~CLOCK2_50;

    int n_vec = 0;
    int n_bad = 0;
    logic [6:0] seg_ref [16];

    typedef struct {
        string      name;
        int         quiet;
        logic [3:0] in;    // {start, miss_left, miss_right, random}
        logic [2:0] st;
        logic [2:0] rbd;   // {game_run, ball_reset, serve_dir}
        logic [3:0] sl;
        logic [3:0] sr;
        logic [1:0] win;
    } vec_t;

    vec_t tv [$];

    function automatic vec_t mk(input string n, input int q, input logic [3:0] in,
                                input logic [2:0] st, input logic [2:0] rbd,
                                input logic [3:0] sl, input logic [3:0] sr,
                                input logic [1:0] win);
        vec_t v;
        v.name = n; v.quiet = q; v.in = in; v.st = st; v.rbd = rbd;
        v.sl = sl; v.sr = sr; v.win = win;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic ml, input logic mr, input logic rnd);
        rst               = r;
        seq_if.start      = s;
        seq_if.miss_left  = ml;
        seq_if.miss_right = mr;
        seq_if.random     = rnd;
        @(posedge CLOCK2_50);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic run,
                             input logic br, input logic dir, input logic [3:0] sl,
                             input logic [3:0] sr, input logic [1:0] win);
        check({tag, ".state"},       16'(seq_if.state),       16'(st));
        check({tag, ".game_run"},    16'(seq_if.game_run),    16'(run));
        check({tag, ".ball_reset"},  16'(seq_if.ball_reset),  16'(br));
        check({tag, ".serve_dir"},   16'(seq_if.serve_dir),   16'(dir));
        check({tag, ".score_left"},  16'(seq_if.score_left),  16'(sl));
        check({tag, ".score_right"}, 16'(seq_if.score_right), 16'(sr));
        check({tag, ".winner"},      16'(seq_if.winner),      16'(win));
        check({tag, ".hex_left"},    16'(seq_if.hex_left),    16'(seg_ref[sl]));
        check({tag, ".hex_right"},   16'(seq_if.hex_right),   16'(seg_ref[sr]));
    endtask

    // Phase-level reference: a SERVE or POINT phase is a plain countdown of
    // cycles; scores and winner follow the game rules directly.
    int   m_st, m_sl, m_sr, m_win, m_cyc;
    logic m_dir, m_br, m_prev;

    task automatic model_step(input logic r, input logic s, input logic ml,
                              input logic mr, input logic rnd);
        logic press;
        press  = s && !m_prev;
        m_prev = s;
        m_br   = 1'b0;
        if (r) begin
            m_st = 0; m_sl = 0; m_sr = 0; m_win = 0; m_dir = 1'b0;
            return;
        end
        case (m_st)
            0, 4: if (press) begin
                m_sl = 0; m_sr = 0; m_win = 0; m_dir = rnd; m_br = 1'b1;
                m_st = 1; m_cyc = SERVE_CYC;
            end
            1: if (m_cyc == 1) m_st = 2; else m_cyc--;
            2: if (ml || mr) begin
                if (ml && mr) m_dir = rnd;
                else if (ml) begin m_sr++; m_dir = 1'b0; end
                else begin m_sl++; m_dir = 1'b1; end
                if (m_sl == WIN_SCORE) begin m_st = 4; m_win = 1; end
                else if (m_sr == WIN_SCORE) begin m_st = 4; m_win = 2; end
                else begin m_st = 3; m_cyc = POINT_CYC; end
            end
            3: if (m_cyc == 1) begin
                m_br = 1'b1; m_st = 1; m_cyc = SERVE_CYC;
            end else m_cyc--;
            default: ;
        endcase
    endtask

    initial begin
        int   br_count;
        logic s, ml, mr, rnd, r;

        for (int i = 0; i < 16; i++) seg_ref[i] = 7'b1111111;
        seg_ref[0] = 7'b1000000; seg_ref[1] = 7'b1111001; seg_ref[2] = 7'b0100100;
        seg_ref[3] = 7'b0110000; seg_ref[4] = 7'b0011001; seg_ref[5] = 7'b0010010;
        seg_ref[6] = 7'b0000010; seg_ref[7] = 7'b1111000; seg_ref[8] = 7'b0000000;
        seg_ref[9] = 7'b0010000;

        tv.push_back(mk("idle_quiet",        0, 4'b0000, 3'd0, 3'b000, 0, 0, 2'b00));
        tv.push_back(mk("start_serve",       8, 4'b1001, 3'd1, 3'b011, 0, 0, 2'b00));
        tv.push_back(mk("serve_br_once",     0, 4'b0000, 3'd1, 3'b001, 0, 0, 2'b00));
        tv.push_back(mk("serve_last",        9, 4'b0000, 3'd1, 3'b001, 0, 0, 2'b00));
        tv.push_back(mk("play_rise",         0, 4'b0000, 3'd2, 3'b101, 0, 0, 2'b00));
        tv.push_back(mk("miss_left",         0, 4'b0100, 3'd3, 3'b000, 0, 1, 2'b00));
        tv.push_back(mk("point_last",        6, 4'b0000, 3'd3, 3'b000, 0, 1, 2'b00));
        tv.push_back(mk("point_expire",      0, 4'b0000, 3'd1, 3'b010, 0, 1, 2'b00));
        tv.push_back(mk("serve2_br_once",    0, 4'b0000, 3'd1, 3'b000, 0, 1, 2'b00));
        tv.push_back(mk("serve2_last",       9, 4'b0000, 3'd1, 3'b000, 0, 1, 2'b00));
        tv.push_back(mk("play2",             0, 4'b0000, 3'd2, 3'b100, 0, 1, 2'b00));
        tv.push_back(mk("both_miss",         0, 4'b0110, 3'd3, 3'b000, 0, 1, 2'b00));
        tv.push_back(mk("replay_serve",      7, 4'b0000, 3'd1, 3'b010, 0, 1, 2'b00));
        tv.push_back(mk("play3",            11, 4'b0000, 3'd2, 3'b100, 0, 1, 2'b00));
        tv.push_back(mk("miss_right1",       0, 4'b0010, 3'd3, 3'b001, 1, 1, 2'b00));
        tv.push_back(mk("serve4",            7, 4'b0000, 3'd1, 3'b011, 1, 1, 2'b00));
        tv.push_back(mk("play4",            11, 4'b0000, 3'd2, 3'b101, 1, 1, 2'b00));
        tv.push_back(mk("miss_right2",       0, 4'b0010, 3'd3, 3'b001, 2, 1, 2'b00));
        tv.push_back(mk("serve5",            7, 4'b0000, 3'd1, 3'b011, 2, 1, 2'b00));
        tv.push_back(mk("play5",            11, 4'b0000, 3'd2, 3'b101, 2, 1, 2'b00));
        tv.push_back(mk("miss_right_win",    0, 4'b0010, 3'd4, 3'b001, 3, 1, 2'b01));
        tv.push_back(mk("over_miss_ignored", 0, 4'b0100, 3'd4, 3'b001, 3, 1, 2'b01));
        tv.push_back(mk("over_hold",         5, 4'b0000, 3'd4, 3'b001, 3, 1, 2'b01));

        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);

        foreach (tv[i]) begin
            repeat (tv[i].quiet) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            drive(1'b0, tv[i].in[3], tv[i].in[2], tv[i].in[1], tv[i].in[0]);
            check_all(tv[i].name, tv[i].st, tv[i].rbd[2], tv[i].rbd[1], tv[i].rbd[0],
                      tv[i].sl, tv[i].sr, tv[i].win);
        end

        // Start held in OVER: one restart, one ball_reset, then normal serve.
        br_count = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (seq_if.ball_reset === 1'b1) br_count++;
            if (k == 0) check_all("over_restart", 3'd1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
        end
        check("over_hold_br_count", 16'(br_count), 16'd1);
        check_all("over_hold_end", 3'd2, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);

        // Reset in POINT with one tick left, start held through release.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_all("rst_pt_miss", 3'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 2'b00);
        repeat (4) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("rst_pt_timer1", 3'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 2'b00);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("rst_mid", 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            check("held_start_state", 16'(seq_if.state), 16'd0);
            check("held_start_br", 16'(seq_if.ball_reset), 16'd0);
        end

        for (int v = 0; v < 16; v++) begin
            seg_val = 4'(v);
            #1;
            check($sformatf("seg7_%0d", v), 16'(seg_out), 16'(seg_ref[v]));
        end

        // Randomized play against the phase-level reference.
        s = 1'b0;
        m_prev = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4000; i++) begin
            r   = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 7) == 0) s = ~s;
            ml  = ($urandom_range(0, 24) == 0);
            mr  = ($urandom_range(0, 24) == 0);
            rnd = 1'($urandom_range(0, 1));
            drive(r, s, ml, mr, rnd);
            model_step(r, s, ml, mr, rnd);
            check_all($sformatf("rand%0d", i), 3'(m_st), (m_st == 2), m_br, m_dir,
                      4'(m_sl), 4'(m_sr), 2'(m_win));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
